// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory fetch controller.
package imem_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF     = 11;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = 2;
  localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LAST  = 2'd2,
    LOAD  = 2'd3
  } state_e;

endpackage

// File: rtl/imem_fetch_ctrl_arb.sv
// Alternating-priority arbiter between the IF-stage fetch and the program loader.
module imem_arb (
  input  logic fetch_req,
  input  logic load_req,
  input  logic last_was_load,
  input  logic idle,
  input  logic flush,
  output logic grant_fetch,
  output logic grant_load
);

  logic fetch_eff;

  // A flushed fetch does not compete; fetch wins a tie only right after a load.
  always_comb begin
    fetch_eff   = fetch_req && !flush;
    grant_fetch = idle && fetch_eff && (!load_req || last_was_load);
    grant_load  = idle && load_req && !(fetch_eff && last_was_load);
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Byte-serial instruction fetch sequencer sharing one memory port with a loader.
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  input  logic              flush,
  output logic              inst_valid,
  output logic [31:0]       inst_out,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lwl_q, lwl_d;
  logic [WORD_W-1:0]   shadow_q, shadow_d;
  logic [WORD_W-1:0]   inst_out_d;
  logic                inst_valid_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                mem_we_d;
  logic [7:0]          mem_wdata_d;
  logic                load_ack_d;
  logic                grant_fetch;
  logic                grant_load;
  logic                idle;
  logic                unused_addr_bits;

  assign idle             = (state_q == IDLE);
  assign fetch_ready      = idle && !flush && !(load_req && !lwl_q);
  assign unused_addr_bits = ^{fetch_addr[31:ADDR_W], fetch_addr[1:0]};

  imem_arb u_arb (
    .fetch_req     (fetch_req),
    .load_req      (load_req),
    .last_was_load (lwl_q),
    .idle          (idle),
    .flush         (flush),
    .grant_fetch   (grant_fetch),
    .grant_load    (grant_load)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and datapath update: sequencing, byte capture, arbitration.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    lwl_d        = lwl_q;
    shadow_d     = shadow_q;
    inst_out_d   = inst_out;
    inst_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_fetch) begin
          base_d  = {fetch_addr[ADDR_W-1:2], 2'b00};
          cnt_d   = '0;
          lwl_d   = 1'b0;
          state_d = FETCH;
        end else if (grant_load) begin
          state_d = LOAD;
        end
      end
      FETCH: begin
        if (flush) begin
          cnt_d    = '0;
          shadow_d = '0;
          state_d  = IDLE;
        end else begin
          // Read data lags the address by one cycle, so slot cnt-1 lands now.
          case (cnt_q)
            2'd1:    shadow_d[31:24] = mem_rdata;
            2'd2:    shadow_d[23:16] = mem_rdata;
            2'd3:    shadow_d[15:8]  = mem_rdata;
            default: ;
          endcase
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) state_d = LAST;
        end
      end
      LAST: begin
        if (flush) begin
          shadow_d = '0;
        end else begin
          inst_out_d   = {shadow_q[31:8], mem_rdata};
          inst_valid_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = IDLE;
      end
      LOAD: begin
        lwl_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-port outputs for the upcoming cycle, derived from the next state.
  always_comb begin
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    load_ack_d  = 1'b0;
    case (state_d)
      FETCH: mem_addr_d = base_d + ADDR_W'(cnt_d);
      LOAD: begin
        mem_addr_d  = load_addr;
        mem_we_d    = 1'b1;
        mem_wdata_d = load_data;
        load_ack_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q     <= '0;
      cnt_q      <= '0;
      lwl_q      <= 1'b0;
      shadow_q   <= '0;
      inst_out   <= '0;
      inst_valid <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      load_ack   <= 1'b0;
    end else begin
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      lwl_q      <= lwl_d;
      shadow_q   <= shadow_d;
      inst_out   <= inst_out_d;
      inst_valid <= inst_valid_d;
      mem_addr   <= mem_addr_d;
      mem_we     <= mem_we_d;
      mem_wdata  <= mem_wdata_d;
      load_ack   <= load_ack_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a synchronous byte-memory model.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic        load_req;
  logic [10:0] load_addr;
  logic [7:0]  load_data;
  logic        load_ack;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:2047];
  int          total = 0;
  int          bad   = 0;

  imem_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ack    (load_ack),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous 1-cycle-read byte memory.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Full fetch from the current negedge; checks address sequence and completion.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [10:0] base;
    base = {addr[10:2], 2'b00};
    fetch_addr = addr;
    fetch_req  = 1'b1;
    #1;
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++; $display("FAIL %s_ready got=%b want=1", tag, fetch_ready);
    end
    @(negedge clk);
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_addr !== base + 11'(i)) begin
        bad++; $display("FAIL %s_addr%0d got=%h want=%h", tag, i, mem_addr, base + 11'(i));
      end
      @(negedge clk);
    end
    total++;
    if (inst_valid !== 1'b0) begin
      bad++; $display("FAIL %s_early_valid got=%b want=0", tag, inst_valid);
    end
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b1) begin
      bad++; $display("FAIL %s_valid got=%b want=1", tag, inst_valid);
    end
    total++;
    if (inst_out !== exp) begin
      bad++; $display("FAIL %s_data got=%h want=%h", tag, inst_out, exp);
    end
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++; $display("FAIL %s_ready_after got=%b want=1", tag, fetch_ready);
    end
    @(negedge clk);
    total++;
    if (inst_valid !== 1'b0) begin
      bad++; $display("FAIL %s_pulse_width got=%b want=0", tag, inst_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
    load_req = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({inst_valid, load_ack, mem_we} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {inst_valid, load_ack, mem_we});
    end
    total++;
    if (inst_out !== 32'h0) begin
      bad++; $display("FAIL reset_inst got=%h want=0", inst_out);
    end
    total++;
    if ({mem_addr, mem_wdata} !== 19'h0) begin
      bad++; $display("FAIL reset_mem got=%h/%h want=0/0", mem_addr, mem_wdata);
    end
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b want=1", fetch_ready);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_fetch();
    do_fetch(32'h0, 32'hE3A0_1005, "basic");
  endtask

  task automatic test_misaligned_top();
    do_fetch(32'hFFFF_F7FE, 32'hA1B2_C3D4, "top");
  endtask

  task automatic test_arbitration();
    load_req = 1'b1; load_addr = 11'h200; load_data = 8'h5A;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    #1;
    total++;
    if (fetch_ready !== 1'b0) begin
      bad++; $display("FAIL arb_ready_tie got=%b want=0", fetch_ready);
    end
    @(negedge clk);
    total++;
    if ({load_ack, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 11'h200, 8'h5A}) begin
      bad++; $display("FAIL arb_load1 got=%b%b/%h/%h want=11/200/5a", load_ack, mem_we, mem_addr, mem_wdata);
    end
    load_addr = 11'h201; load_data = 8'hA5;
    @(negedge clk);
    total++;
    if ({fetch_ready, load_ack} !== 2'b10) begin
      bad++; $display("FAIL arb_fetch_turn got=%b%b want=10", fetch_ready, load_ack);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({load_ack, mem_addr} !== {1'b0, 11'(i)}) begin
        bad++; $display("FAIL arb_fetch_addr%0d got=%b/%h want=0/%h", i, load_ack, mem_addr, i);
      end
      @(negedge clk);
    end
    @(negedge clk);
    total++;
    if ({inst_valid, load_ack, inst_out} !== {2'b10, 32'hE3A0_1005}) begin
      bad++; $display("FAIL arb_word got=%b%b/%h want=10/e3a01005", inst_valid, load_ack, inst_out);
    end
    total++;
    if (fetch_ready !== 1'b0) begin
      bad++; $display("FAIL arb_load_turn got=%b want=0", fetch_ready);
    end
    @(negedge clk);
    total++;
    if ({load_ack, mem_addr, mem_wdata} !== {1'b1, 11'h201, 8'hA5}) begin
      bad++; $display("FAIL arb_load2 got=%b/%h/%h want=1/201/a5", load_ack, mem_addr, mem_wdata);
    end
    load_req = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    total++;
    if ({mem[11'h200], mem[11'h201]} !== 16'h5AA5) begin
      bad++; $display("FAIL arb_written got=%h%h want=5aa5", mem[11'h200], mem[11'h201]);
    end
  endtask

  task automatic test_flush();
    fetch_req = 1'b1; fetch_addr = 32'h7FC;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++; $display("FAIL flush_ready got=%b want=1", fetch_ready);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({inst_valid, inst_out} !== {1'b0, 32'hE3A0_1005}) begin
        bad++; $display("FAIL flush_hold%0d got=%b/%h want=0/e3a01005", i, inst_valid, inst_out);
      end
      @(negedge clk);
    end
    fetch_req = 1'b1; fetch_addr = 32'h100; flush = 1'b1;
    #1;
    total++;
    if (fetch_ready !== 1'b0) begin
      bad++; $display("FAIL flush_idle_ready got=%b want=0", fetch_ready);
    end
    @(negedge clk);
    total++;
    if (mem_addr !== 11'h0) begin
      bad++; $display("FAIL flush_idle_block got=%h want=0", mem_addr);
    end
    fetch_req = 1'b0; flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_then_fetch();
    logic [7:0] bytes [4];
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
    for (int i = 0; i < 4; i++) begin
      load_req = 1'b1; load_addr = 11'h100 + 11'(i); load_data = bytes[i];
      @(negedge clk);
      total++;
      if ({load_ack, mem_we, inst_valid} !== 3'b110) begin
        bad++; $display("FAIL load%0d_ack got=%b want=110", i, {load_ack, mem_we, inst_valid});
      end
      load_req = 1'b0;
      @(negedge clk);
    end
    do_fetch(32'h100, 32'h1234_5678, "loaded");
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1; fetch_addr = 32'h100;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({inst_valid, mem_we, load_ack, mem_addr, inst_out} !== 46'h0) begin
      bad++; $display("FAIL rstmid_outputs got=%b%b%b/%h/%h want=000/0/0", inst_valid, mem_we, load_ack, mem_addr, inst_out);
    end
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_ready got=%b want=1", fetch_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_fetch(32'h0, 32'hE3A0_1005, "after_rst");
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'hE3; mem[1] = 8'hA0; mem[2] = 8'h10; mem[3] = 8'h05;
    mem[2044] = 8'hA1; mem[2045] = 8'hB2; mem[2046] = 8'hC3; mem[2047] = 8'hD4;
    test_reset();
    test_basic_fetch();
    test_misaligned_top();
    test_arbitration();
    test_flush();
    test_load_then_fetch();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
